// File: rtl/vvprojectvv_pkg.sv
// Shared VGA timing defaults, colour constants and hit-zone bounds for the
// display controller and the bitchange pixel generator.
package vvprojectvv_pkg;

    localparam int CLK_DIV_DEF     = 4;
    localparam int H_TOTAL_DEF     = 800;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_VIS_START_DEF = 144;
    localparam int H_VIS_END_DEF   = 784;
    localparam int V_TOTAL_DEF     = 525;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_VIS_START_DEF = 35;
    localparam int V_VIS_END_DEF   = 515;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] GREEN = 12'h0F0;

    // Hit zone, half-open on both axes like the visible window
    localparam logic [9:0] HIT_H_START = 10'd144;
    localparam logic [9:0] HIT_H_END   = 10'd784;
    localparam logic [9:0] HIT_V_START = 10'd400;
    localparam logic [9:0] HIT_V_END   = 10'd475;

    function automatic logic in_span(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vvprojectvv_mod_counter.sv
// Enable-gated modulo-MOD up-counter; wrap flags the terminal count so the
// next stage can chain off it.
module vvprojectvv_mod_counter #(
    parameter int MOD = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = (count == W'(MOD - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vvprojectvv_display_controller.sv
// VGA timing source and pixel sink: pixel divider, h/v counters, visible-window
// flag, frame tick and a one-pixel-latency registered sync/RGB output stage.
module vvprojectvv_display_controller
    import vvprojectvv_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_VIS_START = H_VIS_START_DEF,
    parameter int H_VIS_END   = H_VIS_END_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_VIS_START = V_VIS_START_DEF,
    parameter int V_VIS_END   = V_VIS_END_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] rgb_in,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        pix_en,
    output logic        frame_start,
    output logic        hSync,
    output logic        vSync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    if (CLK_DIV < 1 || H_VIS_END > H_TOTAL || V_VIS_END > V_TOTAL ||
        H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vvprojectvv_display_controller: illegal timing parameters");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_en;
    logic [9:0]       h_next;
    logic [9:0]       v_next;

    assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));

    // pix_en is registered so it is 0 in reset even when CLK_DIV is 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            pix_en  <= div_wrap;
        end
    end

    assign v_en = pix_en & h_wrap;

    vvprojectvv_mod_counter #(.MOD(H_TOTAL), .W(10)) u_hcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pix_en),
        .count   (hCount),
        .wrap    (h_wrap)
    );

    vvprojectvv_mod_counter #(.MOD(V_TOTAL), .W(10)) u_vcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (v_en),
        .count   (vCount),
        .wrap    (v_wrap)
    );

    // bright is evaluated on the counters' next values so it lines up with them
    assign h_next = pix_en ? (h_wrap ? 10'd0 : hCount + 10'd1) : hCount;
    assign v_next = v_en   ? (v_wrap ? 10'd0 : vCount + 10'd1) : vCount;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            bright      <= in_span(h_next, 10'(H_VIS_START), 10'(H_VIS_END)) &&
                           in_span(v_next, 10'(V_VIS_START), 10'(V_VIS_END));
            frame_start <= v_en & v_wrap;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hSync <= 1'b1;
            vSync <= 1'b1;
            vga_r <= 4'h0;
            vga_g <= 4'h0;
            vga_b <= 4'h0;
        end else if (pix_en) begin
            hSync <= !(hCount < 10'(H_SYNC));
            vSync <= !(vCount < 10'(V_SYNC));
            vga_r <= bright ? rgb_in[11:8] : 4'h0;
            vga_g <= bright ? rgb_in[7:4]  : 4'h0;
            vga_b <= bright ? rgb_in[3:0]  : 4'h0;
        end
    end

endmodule

// File: tb/tb_vvprojectvv_display_controller.sv
// Directed bench for the display controller on a shrunken raster, with a
// cycle model of divider/counters and a queue of expected pin values.
module tb_vvprojectvv_display_controller;
    import vvprojectvv_pkg::*;

    localparam int D   = 4;
    localparam int HT  = 20;
    localparam int HS  = 3;
    localparam int HVS = 5;
    localparam int HVE = 17;
    localparam int VT  = 12;
    localparam int VS  = 2;
    localparam int VVS = 3;
    localparam int VVE = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] rgb_in = 12'h000;
    logic [9:0]  hCount, vCount;
    logic        bright, pix_en, frame_start, hSync, vSync;
    logic [3:0]  vga_r, vga_g, vga_b;

    vvprojectvv_display_controller #(
        .CLK_DIV(D), .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in),
        .hCount(hCount), .vCount(vCount), .bright(bright), .pix_en(pix_en),
        .frame_start(frame_start), .hSync(hSync), .vSync(vSync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          k, mh, mv, rgb_mode;
    logic        pe_exp, fs_exp;
    logic [13:0] pins_exp;
    logic [13:0] sbq[$];
    int          fs_count, hs_low, vs_low, red_pix, sync_col, hmax, vmax;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic vis(input int h, input int v);
        return (h >= HVS) && (h < HVE) && (v >= VVS) && (v < VVE);
    endfunction

    function automatic logic [11:0] pattern(input int mode, input int h, input int v);
        if (mode == 0) return RED;
        return 12'((h * 37 + v * 11 + 1) & 32'hFFF);
    endfunction

    task automatic model_reset();
        k = 0; mh = 0; mv = 0;
        pe_exp = 1'b0; fs_exp = 1'b0;
        pins_exp = {1'b1, 1'b1, 12'h000};
        sbq.delete();
    endtask

    task automatic clear_stats();
        fs_count = 0; hs_low = 0; vs_low = 0; red_pix = 0; sync_col = 0; hmax = 0; vmax = 0;
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_pix_en"}, pix_en, 0);
        chk({pfx, "_frame_start"}, frame_start, 0);
        chk({pfx, "_bright"}, bright, 0);
        chk({pfx, "_hCount"}, hCount, 0);
        chk({pfx, "_vCount"}, vCount, 0);
        chk({pfx, "_syncs"}, {hSync, vSync}, 2'b11);
        chk({pfx, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    endtask

    task automatic step(input int n);
        logic upd;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            upd = pe_exp;
            if (pe_exp) begin
                sbq.push_back({logic'(mh >= HS), logic'(mv >= VS),
                               (vis(mh, mv) ? rgb_in : 12'h000)});
                fs_exp = (mh == HT - 1) && (mv == VT - 1);
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
                pins_exp = sbq.pop_front();
            end else begin
                fs_exp = 1'b0;
            end
            pe_exp = (k % D == 0);
            @(negedge clk);
            chk("pix_en", pix_en, pe_exp);
            chk("hCount", hCount, mh);
            chk("vCount", vCount, mv);
            chk("bright", bright, vis(mh, mv));
            chk("frame_start", frame_start, fs_exp);
            chk("pins", {hSync, vSync, vga_r, vga_g, vga_b}, pins_exp);
            if (frame_start) fs_count++;
            if (int'(hCount) > hmax) hmax = int'(hCount);
            if (int'(vCount) > vmax) vmax = int'(vCount);
            if (upd) begin
                if (!hSync) hs_low++;
                if (!vSync) vs_low++;
                if ((!hSync || !vSync) && ({vga_r, vga_g, vga_b} != 12'h000)) sync_col++;
                if (vga_r == 4'hF) red_pix++;
            end
            rgb_in = pattern(rgb_mode, mh, mv);
        end
    endtask

    initial begin
        model_reset();
        clear_stats();
        rgb_mode = 0;
        rgb_in = pattern(rgb_mode, 0, 0);

        // power-on reset for 3 clocks
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        reset_n = 1'b1;

        step(D);
        chk("first_pix_en_edge", pix_en, 1);
        chk("h_before_first_update", hCount, 0);
        step(1);
        chk("h_after_first_update", hCount, 1);

        // complete the first frame: last pixel update lands at edge D+1+(HT*VT-1)*D
        step(D + 1 + (HT * VT - 1) * D - k);
        chk("frame1_fs_count", fs_count, 1);
        chk("frame1_hmax", hmax, HT - 1);
        chk("frame1_vmax", vmax, VT - 1);
        chk("frame1_hsync_low_pixels", hs_low, HS * VT);
        chk("frame1_vsync_low_pixels", vs_low, VS * HT);
        chk("frame1_red_pixels", red_pix, (HVE - HVS) * (VVE - VVS));
        chk("frame1_colour_in_sync", sync_col, 0);

        // position-dependent colour for a few lines
        rgb_mode = 1;
        step(HT * D * 3);

        // walk to (10,6) and drop reset between clock edges mid-pixel
        for (int i = 0; i < HT * VT * D && !(mh == 10 && mv == 6); i++) step(1);
        step(1);
        chk("midreset_at_h", hCount, 10);
        chk("midreset_at_v", vCount, 6);
        #2 reset_n = 1'b0;
        #1 check_reset("async");
        @(negedge clk);
        check_reset("held");
        reset_n = 1'b1;
        model_reset();
        clear_stats();

        step(D + (HT * VT - 1) * D);
        chk("restart_no_early_fs", fs_count, 0);
        step(1);
        chk("restart_fs_count", fs_count, 1);
        chk("restart_fs_now", frame_start, 1);
        step(D * 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
